// File: rtl/toggle_fsm_pkg.sv
// Shared types for the toggle FSM bank: event-qualification modes and channel state.
package toggle_fsm_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL     = 2'd0,
        MODE_EDGE      = 2'd1,
        MODE_QUALIFIED = 2'd2,
        MODE_HOLD      = 2'd3
    } mode_t;

    typedef enum logic [0:0] {
        STATE_A = 1'b0,
        STATE_B = 1'b1
    } tfsm_state_t;

    // Width of a run counter that must be able to hold the value max_val.
    function automatic int run_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/toggle_fsm_channel.sv
// One toggle channel: two-state Moore FSM, input history for edge/qualified
// detection, saturating toggle counter and a registered toggled pulse.
module toggle_fsm_channel
    import toggle_fsm_pkg::*;
#(
    parameter int   QUAL_CYCLES = 3,
    parameter int   CNT_W       = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  mode_t            mode_i,
    input  logic             in_i,
    input  logic             clr_cnt_i,
    output logic             out_o,
    output logic             toggled_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int QW = run_width(QUAL_CYCLES);
    localparam logic [QW-1:0]    QUAL_MAX  = QW'(QUAL_CYCLES);
    localparam logic [QW-1:0]    QUAL_FIRE = QW'(QUAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam tfsm_state_t      STATE_RST = RESET_VAL ? STATE_B : STATE_A;

    tfsm_state_t      state_q, state_d;
    logic             prev_in_q, prev_in_d;
    logic [QW-1:0]    qual_cnt_q, qual_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggled_q, toggled_d;
    logic             fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= STATE_RST;
            prev_in_q  <= 1'b0;
            qual_cnt_q <= '0;
            cnt_q      <= '0;
            toggled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_in_q  <= prev_in_d;
            qual_cnt_q <= qual_cnt_d;
            cnt_q      <= cnt_d;
            toggled_q  <= toggled_d;
        end
    end

    always_comb begin
        fire = 1'b0;
        case (mode_i)
            MODE_LEVEL:     fire = in_i;
            MODE_EDGE:      fire = in_i & ~prev_in_q;
            MODE_QUALIFIED: fire = in_i & (qual_cnt_q == QUAL_FIRE);
            MODE_HOLD:      fire = 1'b0;
            default:        fire = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_A: state_d = fire ? STATE_B : STATE_A;
            STATE_B: state_d = fire ? STATE_A : STATE_B;
            default: state_d = STATE_A;
        endcase
    end

    // History tracks the input in every mode so that a mode switch never
    // sees a stale edge or a partially counted run.
    always_comb begin
        prev_in_d  = in_i;
        qual_cnt_d = '0;
        if (in_i) begin
            qual_cnt_d = (qual_cnt_q == QUAL_MAX) ? QUAL_MAX : qual_cnt_q + QW'(1);
        end
    end

    // Clear beats a same-cycle increment; the counter saturates instead of wrapping.
    always_comb begin
        cnt_d     = cnt_q;
        toggled_d = fire;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign out_o     = (state_q == STATE_B);
    assign toggled_o = toggled_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/toggle_fsm_bank.sv
// Bank of independent toggle channels sharing one mode select and counter clear;
// per-channel counts are packed side by side on toggle_cnt.
module toggle_fsm_bank
    import toggle_fsm_pkg::*;
#(
    parameter int                  CHANNELS    = 4,
    parameter int                  QUAL_CYCLES = 3,
    parameter int                  CNT_W       = 8,
    parameter logic [CHANNELS-1:0] RESET_STATE = {CHANNELS{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       in,
    input  logic                      clr_cnt,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       toggled,
    output logic [CHANNELS*CNT_W-1:0] toggle_cnt
);

    mode_t mode_e;
    assign mode_e = mode_t'(mode);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            toggle_fsm_channel #(
                .QUAL_CYCLES (QUAL_CYCLES),
                .CNT_W       (CNT_W),
                .RESET_VAL   (RESET_STATE[gi])
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .mode_i    (mode_e),
                .in_i      (in[gi]),
                .clr_cnt_i (clr_cnt),
                .out_o     (out[gi]),
                .toggled_o (toggled[gi]),
                .cnt_o     (toggle_cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_toggle_fsm_bank.sv
// Randomized and directed check of toggle_fsm_bank against a behavioural model,
// using three parameterizations driven by the same stimulus.
module tb_toggle_fsm_bank;

    localparam int NI = 3;
    localparam int CH = 4;

    logic       clk = 1'b0;
    logic       reset_r = 1'b1;
    logic [1:0] mode_r = 2'd0;
    logic [3:0] in_r = 4'd0;
    logic       clr_r = 1'b0;

    logic [3:0]  out0, tog0, out1, tog1, out2, tog2;
    logic [31:0] cnt0;
    logic [7:0]  cnt1;
    logic [11:0] cnt2;

    always #5 clk = ~clk;

    toggle_fsm_bank #(.CHANNELS(4), .QUAL_CYCLES(3), .CNT_W(8), .RESET_STATE(4'b0000)) dut0 (
        .clk(clk), .reset(reset_r), .mode(mode_r), .in(in_r), .clr_cnt(clr_r),
        .out(out0), .toggled(tog0), .toggle_cnt(cnt0));
    toggle_fsm_bank #(.CHANNELS(4), .QUAL_CYCLES(3), .CNT_W(2), .RESET_STATE(4'b1010)) dut1 (
        .clk(clk), .reset(reset_r), .mode(mode_r), .in(in_r), .clr_cnt(clr_r),
        .out(out1), .toggled(tog1), .toggle_cnt(cnt1));
    toggle_fsm_bank #(.CHANNELS(4), .QUAL_CYCLES(1), .CNT_W(3), .RESET_STATE(4'b0101)) dut2 (
        .clk(clk), .reset(reset_r), .mode(mode_r), .in(in_r), .clr_cnt(clr_r),
        .out(out2), .toggled(tog2), .toggle_cnt(cnt2));

    int qc[NI]  = '{3, 3, 1};
    int cw[NI]  = '{8, 2, 3};
    int rst[NI] = '{0, 10, 5};

    // Model: state bit, count, last input, length of the current high run.
    int st[NI][CH], cm[NI][CH], pv[NI][CH], run[NI][CH], tg[NI][CH];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < CH; i++) begin
                int f;
                if (reset_r) begin
                    st[k][i] = (rst[k] >> i) & 1;
                    cm[k][i] = 0; pv[k][i] = 0; run[k][i] = 0; tg[k][i] = 0;
                end else begin
                    case (mode_r)
                        2'd0: f = in_r[i];
                        2'd1: f = (in_r[i] && pv[k][i] == 0) ? 1 : 0;
                        2'd2: f = (in_r[i] && run[k][i] == qc[k] - 1) ? 1 : 0;
                        default: f = 0;
                    endcase
                    tg[k][i] = f;
                    if (f != 0) st[k][i] = 1 - st[k][i];
                    if (clr_r) cm[k][i] = 0;
                    else if (f != 0 && cm[k][i] < (1 << cw[k]) - 1) cm[k][i]++;
                    pv[k][i] = in_r[i];
                    run[k][i] = in_r[i] ? ((run[k][i] < 1000) ? run[k][i] + 1 : run[k][i]) : 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            logic [31:0] eo, et, ec, go, gt, gc;
            eo = 0; et = 0; ec = 0;
            for (int i = 0; i < CH; i++) begin
                eo[i] = st[k][i][0];
                et[i] = tg[k][i][0];
                ec = ec | (32'(cm[k][i]) << (i * cw[k]));
            end
            case (k)
                0: begin go = {28'd0, out0}; gt = {28'd0, tog0}; gc = cnt0; end
                1: begin go = {28'd0, out1}; gt = {28'd0, tog1}; gc = {24'd0, cnt1}; end
                default: begin go = {28'd0, out2}; gt = {28'd0, tog2}; gc = {20'd0, cnt2}; end
            endcase
            check($sformatf("out%0d", k), go, eo);
            check($sformatf("toggled%0d", k), gt, et);
            check($sformatf("cnt%0d", k), gc, ec);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        $display("cyc %0d rst=%0b mode=%0d in=%b clr=%0b | out0=%b tog0=%b cnt0=%h | out1=%b cnt1=%h | out2=%b cnt2=%h",
                 cyc, reset_r, mode_r, in_r, clr_r, out0, tog0, cnt0, out1, cnt1, out2, cnt2);
        cyc++;
    endtask

    task automatic drive(input logic r, input logic [1:0] m, input logic [3:0] v, input logic c);
        reset_r = r; mode_r = m; in_r = v; clr_r = c;
        step();
    endtask

    initial begin
        logic lvl_seq [3];
        logic [1:0] sat_seq [6];
        lvl_seq = '{1'b1, 1'b0, 1'b1};
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        repeat (3) drive(1'b1, 2'd0, 4'd0, 1'b0);
        check("rst_out0", {28'd0, out0}, 32'h0);
        check("rst_out1", {28'd0, out1}, 32'ha);
        check("rst_out2", {28'd0, out2}, 32'h5);
        check("rst_cnt0", cnt0, 32'h0);
        check("rst_tog0", {28'd0, tog0}, 32'h0);

        // LEVEL on ch0
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, 2'd0, 4'b0001, 1'b0);
            check("lvl_out", {31'd0, out0[0]}, {31'd0, lvl_seq[j]});
            check("lvl_tog", {28'd0, tog0}, 32'h1);
        end
        check("lvl_cnt", {24'd0, cnt0[7:0]}, 32'd3);
        check("lvl_others", {29'd0, out0[3:1]}, 32'h0);
        drive(1'b0, 2'd0, 4'b0000, 1'b0);

        // EDGE on ch1
        repeat (5) drive(1'b0, 2'd1, 4'b0010, 1'b0);
        drive(1'b0, 2'd1, 4'b0000, 1'b0);
        drive(1'b0, 2'd1, 4'b0010, 1'b0);
        check("edge_out", {31'd0, out0[1]}, 32'h0);
        check("edge_cnt", {24'd0, cnt0[15:8]}, 32'd2);
        drive(1'b0, 2'd1, 4'b0000, 1'b0);

        // QUALIFIED on ch2
        repeat (2) drive(1'b0, 2'd2, 4'b0100, 1'b0);
        drive(1'b0, 2'd2, 4'b0000, 1'b0);
        repeat (4) drive(1'b0, 2'd2, 4'b0100, 1'b0);
        check("qual_out", {31'd0, out0[2]}, 32'h1);
        check("qual_cnt", {24'd0, cnt0[23:16]}, 32'd1);

        // HOLD then EDGE with inputs already high
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 2'd3, 4'b1111, 1'b0);
            check("hold_tog", {28'd0, tog0}, 32'h0);
        end
        drive(1'b0, 2'd1, 4'b1111, 1'b0);
        check("hold_edge_tog", {28'd0, tog0}, 32'h0);
        check("hold_out", {28'd0, out0}, 32'h5);
        check("hold_cnt", cnt0, 32'h00010203);

        // CNT_W=2 saturation and clear vs increment
        repeat (2) drive(1'b1, 2'd0, 4'd0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, 2'd0, 4'b0001, 1'b0);
            check("sat_cnt", {30'd0, cnt1[1:0]}, {30'd0, sat_seq[j]});
        end
        drive(1'b0, 2'd0, 4'b0001, 1'b1);
        check("clr_cnt", {30'd0, cnt1[1:0]}, 32'h0);
        check("clr_out", {31'd0, out1[0]}, 32'h1);
        drive(1'b0, 2'd0, 4'b0000, 1'b0);

        // Reset in the middle of a qualification run
        repeat (2) drive(1'b0, 2'd2, 4'b1111, 1'b0);
        drive(1'b1, 2'd2, 4'b1111, 1'b0);
        check("mq_rst_out", {28'd0, out1}, 32'ha);
        check("mq_rst_cnt", {24'd0, cnt1}, 32'h0);
        for (int j = 0; j < 2; j++) begin
            drive(1'b0, 2'd2, 4'b1111, 1'b0);
            check("mq_nofire", {28'd0, tog1}, 32'h0);
        end
        drive(1'b0, 2'd2, 4'b1111, 1'b0);
        check("mq_fire_tog", {28'd0, tog1}, 32'hf);
        check("mq_fire_out", {28'd0, out1}, 32'h5);

        // Randomized phase with sticky mode and inputs
        for (int j = 0; j < 1500; j++) begin
            logic [3:0] v;
            logic [1:0] m;
            v = in_r;
            m = mode_r;
            for (int i = 0; i < CH; i++) if ($urandom_range(3) == 0) v[i] = ~v[i];
            if ($urandom_range(7) == 0) m = 2'($urandom_range(3));
            drive(($urandom_range(199) == 0), m, v, ($urandom_range(63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
